music_player: RTL and testbench

MUSIC_PLAYER -- requirements
Module: music_player

---
 rtl/music_player.sv | 173 +++++++++++++++++
 tb/tb_music_player.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/music_player.sv
// Buzzer music player: plays one of four built-in songs as a square wave.
// INIT and PLAY loop forever. WIN and LOSS play once and then go silent.
// Each note lasts BEAT_CYCLES clocks. The last GAP_CYCLES clocks of every
// beat are silent, so repeated notes are heard as separate notes.
module music_player #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] music,
  output logic       audio_pwm,
  output logic       audio_sd,
  output logic [4:0] note_idx,
  output logic       busy
);

  // The lowest pitch in any song (C4) sets the width of the tone counter.
  localparam int MIN_HZ       = 262;
  localparam int MAX_HALF     = CLK_HZ / (2 * MIN_HZ);
  localparam int HW           = $clog2(MAX_HALF + 1);
  localparam int BW           = $clog2(BEAT_CYCLES + 1);
  localparam int SOUND_CYCLES = BEAT_CYCLES - GAP_CYCLES;

  // Note frequencies in Hz. A value of 0 is a rest.
  localparam int INIT_HZ [16] = '{523, 659, 784, 659, 523, 0, 523, 659,
                                  784, 1047, 784, 659, 587, 0, 523, 0};
  localparam int PLAY_HZ [32] = '{659, 0, 659, 0, 523, 659, 784, 0,
                                  392, 0, 523, 392, 330, 440, 494, 466,
                                  440, 392, 659, 784, 880, 698, 784, 0,
                                  659, 523, 587, 494, 0, 523, 0, 0};
  localparam int WIN_HZ  [8]  = '{784, 880, 988, 1047, 0, 1047, 1175, 1319};
  localparam int LOSS_HZ [8]  = '{262, 0, 277, 262, 0, 294, 277, 262};

  function automatic int half_of(input int hz);
    return (hz == 0) ? 0 : CLK_HZ / (2 * hz);
  endfunction

  typedef enum logic [1:0] {IDLE, PLAYING, DONE} state_t;

  // Half-period tables. These are elaboration-time constants, so there is
  // no divider in the hardware.
  logic [HW-1:0] init_rom [16];
  logic [HW-1:0] play_rom [32];
  logic [HW-1:0] win_rom  [8];
  logic [HW-1:0] loss_rom [8];

  for (genvar i = 0; i < 16; i++) begin : g_init
    assign init_rom[i] = HW'(half_of(INIT_HZ[i]));
  end
  for (genvar i = 0; i < 32; i++) begin : g_play
    assign play_rom[i] = HW'(half_of(PLAY_HZ[i]));
  end
  for (genvar i = 0; i < 8; i++) begin : g_short
    assign win_rom[i]  = HW'(half_of(WIN_HZ[i]));
    assign loss_rom[i] = HW'(half_of(LOSS_HZ[i]));
  end

  state_t        state_q, state_d;
  logic [3:0]    mode_q, mode_d;
  logic [3:0]    song_q, song_d;
  logic [4:0]    idx_q, idx_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [HW-1:0] tone_q, tone_d;
  logic          pwm_q, pwm_d;

  logic [HW-1:0] entry;
  logic [4:0]    last_idx;
  logic          one_shot;
  logic          mode_valid;
  logic          sounding;
  logic          beat_end;

  // Song lookup. song_q holds the song that is playing. mode_q holds the
  // current selection. When the two differ, playback restarts.
  always_comb begin
    entry    = '0;
    last_idx = 5'd0;
    one_shot = 1'b0;
    case (song_q)
      4'b0001: begin entry = init_rom[idx_q[3:0]]; last_idx = 5'd15; end
      4'b0010: begin entry = play_rom[idx_q];      last_idx = 5'd31; end
      4'b0100: begin entry = win_rom[idx_q[2:0]];  last_idx = 5'd7; one_shot = 1'b1; end
      4'b1000: begin entry = loss_rom[idx_q[2:0]]; last_idx = 5'd7; one_shot = 1'b1; end
      default: ;
    endcase
  end

  assign mode_valid = $onehot(mode_q);
  assign beat_end   = (beat_q == BW'(BEAT_CYCLES - 1));
  assign sounding   = (state_q == PLAYING) && (entry != '0) &&
                      (beat_q < BW'(SOUND_CYCLES));

  // Next-state logic. An invalid selection forces the player back to IDLE.
  // A new valid selection restarts the new song at note 0.
  always_comb begin
    mode_d  = music;
    state_d = state_q;
    song_d  = song_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    tone_d  = tone_q;
    pwm_d   = pwm_q;
    if (!mode_valid) begin
      state_d = IDLE;
      song_d  = '0;
      idx_d   = '0;
      beat_d  = '0;
      tone_d  = '0;
      pwm_d   = 1'b0;
    end else if (state_q == IDLE || mode_q != song_q) begin
      state_d = PLAYING;
      song_d  = mode_q;
      idx_d   = '0;
      beat_d  = '0;
      tone_d  = '0;
      pwm_d   = 1'b0;
    end else if (state_q == PLAYING) begin
      if (beat_end) begin
        beat_d = '0;
        tone_d = '0;
        pwm_d  = 1'b0;
        if (idx_q == last_idx) begin
          if (one_shot) state_d = DONE;
          else          idx_d   = '0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end else begin
        beat_d = beat_q + BW'(1);
        if (sounding) begin
          if (tone_q == entry - HW'(1)) begin
            tone_d = '0;
            pwm_d  = ~pwm_q;
          end else begin
            tone_d = tone_q + HW'(1);
          end
        end else begin
          tone_d = '0;
          pwm_d  = 1'b0;
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      song_q  <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      tone_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      song_q  <= song_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      tone_q  <= tone_d;
      pwm_q   <= pwm_d;
    end
  end

  assign audio_sd  = sounding;
  assign audio_pwm = pwm_q & sounding;
  assign note_idx  = idx_q;
  assign busy      = (state_q == PLAYING);

endmodule

// File: tb/tb_music_player.sv
// Testbench for music_player. It uses small timing parameters.
// The reference model works from elapsed time since playback started:
// note = elapsed / beat, and tone phase = position-in-beat / half-period.
module tb_music_player;

  localparam int CLK_HZ = 40_000;
  localparam int BEAT   = 100;
  localparam int GAP    = 10;
  localparam int SOUND  = BEAT - GAP;

  localparam int M_IDLE    = 0;
  localparam int M_PLAYING = 1;
  localparam int M_DONE    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] music;
  logic       audio_pwm;
  logic       audio_sd;
  logic [4:0] note_idx;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit compare_en = 1'b0;

  int init_hz [16] = '{523, 659, 784, 659, 523, 0, 523, 659,
                       784, 1047, 784, 659, 587, 0, 523, 0};
  int play_hz [32] = '{659, 0, 659, 0, 523, 659, 784, 0,
                       392, 0, 523, 392, 330, 440, 494, 466,
                       440, 392, 659, 784, 880, 698, 784, 0,
                       659, 523, 587, 494, 0, 523, 0, 0};
  int win_hz  [8]  = '{784, 880, 988, 1047, 0, 1047, 1175, 1319};
  int loss_hz [8]  = '{262, 0, 277, 262, 0, 294, 277, 262};

  // Model state. m_mode is the registered selection.
  // m_start is the cycle on which the current song started.
  int         cyc = 0;
  int         m_state = M_IDLE;
  logic [3:0] m_mode = '0;
  logic [3:0] m_song = '0;
  int         m_start = 0;

  music_player #(
    .CLK_HZ(CLK_HZ),
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .music(music),
    .audio_pwm(audio_pwm),
    .audio_sd(audio_sd),
    .note_idx(note_idx),
    .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic int song_len(input logic [3:0] s);
    case (s)
      4'b0001: return 16;
      4'b0010: return 32;
      default: return 8;
    endcase
  endfunction

  function automatic bit song_once(input logic [3:0] s);
    return (s == 4'b0100) || (s == 4'b1000);
  endfunction

  function automatic int note_hz(input logic [3:0] s, input int i);
    case (s)
      4'b0001: return init_hz[i];
      4'b0010: return play_hz[i];
      4'b0100: return win_hz[i];
      default: return loss_hz[i];
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] m, input int n);
    rst   = r;
    music = m;
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model. On every rising edge it steps the song state.
  // It uses the selection registered on the previous edge, then
  // registers the new selection.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_state = M_IDLE;
      m_mode  = '0;
      m_song  = '0;
    end else begin
      if ($countones(m_mode) != 1) begin
        m_state = M_IDLE;
        m_song  = '0;
      end else if (m_state == M_IDLE || m_mode != m_song) begin
        m_state = M_PLAYING;
        m_song  = m_mode;
        m_start = cyc;
      end else if (m_state == M_PLAYING && song_once(m_song) &&
                   (cyc - m_start) >= song_len(m_song) * BEAT) begin
        m_state = M_DONE;
      end
      m_mode = music;
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (compare_en) begin
      int e_busy, e_sd, e_pwm, e_idx;
      int el, pos, hz, half;
      e_busy = 0; e_sd = 0; e_pwm = 0; e_idx = 0;
      if (m_state == M_PLAYING) begin
        el     = cyc - m_start;
        pos    = el % BEAT;
        e_idx  = (el / BEAT) % song_len(m_song);
        hz     = note_hz(m_song, e_idx);
        half   = (hz == 0) ? 0 : CLK_HZ / (2 * hz);
        e_busy = 1;
        e_sd   = (half != 0 && pos < SOUND) ? 1 : 0;
        e_pwm  = (e_sd == 1 && ((pos / half) % 2) == 1) ? 1 : 0;
      end else if (m_state == M_DONE) begin
        e_idx = song_len(m_song) - 1;
      end
      checkOutput("cyc_busy", int'(busy), e_busy);
      checkOutput("cyc_sd", int'(audio_sd), e_sd);
      checkOutput("cyc_pwm", int'(audio_pwm), e_pwm);
      checkOutput("cyc_idx", int'(note_idx), e_idx);
    end
  end

  // Directed scenarios with hand-computed expectations, followed by random selections.
  initial begin
    logic [3:0] v;
    applyStimulus(1'b1, 4'b0000, 3);
    compare_en = 1'b1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_idx", int'(note_idx), 0);
    checkOutput("rst_sd", int'(audio_sd), 0);

    // INIT: C5 has a half-period of 38 cycles at 40 kHz.
    applyStimulus(1'b0, 4'b0001, 2);
    checkOutput("init_busy", int'(busy), 1);
    checkOutput("init_sd", int'(audio_sd), 1);
    checkOutput("init_pwm0", int'(audio_pwm), 0);
    applyStimulus(1'b0, 4'b0001, 37);
    checkOutput("pre_rise", int'(audio_pwm), 0);
    applyStimulus(1'b0, 4'b0001, 1);
    checkOutput("first_rise", int'(audio_pwm), 1);
    applyStimulus(1'b0, 4'b0001, 51);
    checkOutput("sd_pos89", int'(audio_sd), 1);
    applyStimulus(1'b0, 4'b0001, 1);
    checkOutput("gap_sd", int'(audio_sd), 0);
    checkOutput("gap_pwm", int'(audio_pwm), 0);
    applyStimulus(1'b0, 4'b0001, 10);
    checkOutput("idx1", int'(note_idx), 1);
    applyStimulus(1'b0, 4'b0001, 1400);
    checkOutput("idx15", int'(note_idx), 15);
    applyStimulus(1'b0, 4'b0001, 100);
    checkOutput("wrap", int'(note_idx), 0);
    applyStimulus(1'b0, 4'b0001, 500);
    checkOutput("idx5", int'(note_idx), 5);

    // Switch to PLAY in the middle of a note.
    applyStimulus(1'b0, 4'b0010, 1);
    checkOutput("switch_hold", int'(note_idx), 5);
    applyStimulus(1'b0, 4'b0010, 1);
    checkOutput("switch_idx", int'(note_idx), 0);
    checkOutput("switch_pwm", int'(audio_pwm), 0);
    checkOutput("switch_busy", int'(busy), 1);
    applyStimulus(1'b0, 4'b0010, 900);
    checkOutput("play_idx9", int'(note_idx), 9);

    // Reset during PLAY, then release it.
    applyStimulus(1'b1, 4'b0010, 1);
    checkOutput("rstmid_busy", int'(busy), 0);
    checkOutput("rstmid_sd", int'(audio_sd), 0);
    checkOutput("rstmid_idx", int'(note_idx), 0);
    applyStimulus(1'b0, 4'b0010, 1);
    checkOutput("rel_busy1", int'(busy), 0);
    applyStimulus(1'b0, 4'b0010, 1);
    checkOutput("rel_busy2", int'(busy), 1);
    checkOutput("rel_idx", int'(note_idx), 0);

    // A multi-hot selection drops the player to idle.
    applyStimulus(1'b0, 4'b0011, 2);
    checkOutput("inv_busy", int'(busy), 0);
    checkOutput("inv_sd", int'(audio_sd), 0);

    // WIN plays once and then finishes. LOSS then starts from note 0.
    applyStimulus(1'b0, 4'b0100, 2);
    checkOutput("win_busy", int'(busy), 1);
    applyStimulus(1'b0, 4'b0100, 799);
    checkOutput("win_last", int'(note_idx), 7);
    applyStimulus(1'b0, 4'b0100, 1);
    checkOutput("win_done_busy", int'(busy), 0);
    checkOutput("win_done_idx", int'(note_idx), 7);
    checkOutput("win_done_sd", int'(audio_sd), 0);
    applyStimulus(1'b0, 4'b0100, 50);
    checkOutput("win_hold_idx", int'(note_idx), 7);
    applyStimulus(1'b0, 4'b1000, 2);
    checkOutput("loss_busy", int'(busy), 1);
    checkOutput("loss_idx", int'(note_idx), 0);
    checkOutput("loss_sd", int'(audio_sd), 1);
    applyStimulus(1'b0, 4'b0000, 2);
    checkOutput("zero_busy", int'(busy), 0);

    // Random mix of song selections, invalid selections and reset pulses.
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        applyStimulus(1'b1, 4'($urandom_range(0, 15)), $urandom_range(1, 3));
      end else if (r == 1) begin
        applyStimulus(1'b0, 4'($urandom_range(0, 15)), $urandom_range(1, 20));
      end else begin
        v = 4'b0001 << $urandom_range(0, 3);
        applyStimulus(1'b0, v, $urandom_range(1, 900));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
